// File: rtl/shift_cmd_sequencer.sv
// rtl/shift_cmd_sequencer.sv - buffered shift/rotate command front-end with chain accumulator
//
// Ports:
//   clk, nrst       clock (rising edge), asynchronous active-low reset
//   flush           synchronous clear of FIFO, output register and accumulator
//   in_valid/ready  command handshake; in_ready = !fifo_full && !flush
//   in_data         operand (unused when in_chain=1)
//   in_n            amount 0..15, saturated to 8
//   in_ar/lr/rot    arithmetic, left, rotate selects
//   in_chain        take the operand from the accumulator
//   out_valid/ready result handshake
//   out_data        registered result
//   level           FIFO occupancy 0..DEPTH

module shift_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic [3:0]               in_n,
  input  logic                     in_ar,
  input  logic                     in_lr,
  input  logic                     in_rot,
  input  logic                     in_chain,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] n;
    logic       ar;
    logic       lr;
    logic       rot;
    logic       chain;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    acc;

  logic          full;
  logic          push;
  logic          pop;
  cmd_t          head;
  logic [7:0]    op;
  logic [3:0]    k;
  logic [15:0]   dbl;
  logic [15:0]   rol_w;
  logic [15:0]   ror_w;
  logic [7:0]    res;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  // The output register can take a new result when empty or being drained this edge.
  assign pop      = (count != '0) && (!out_valid || out_ready) && !flush;
  assign level    = count;

  always_comb begin
    head  = mem[rd_ptr];
    op    = head.chain ? acc : head.data;
    k     = (head.n > 4'd8) ? 4'd8 : head.n;
    // Rotations via a doubled operand: k=0 and k=8 both fall out as identity.
    dbl   = {op, op};
    rol_w = dbl << k;
    ror_w = dbl >> k;
    res   = 8'h00;
    if (head.rot)
      res = head.lr ? rol_w[15:8] : ror_w[7:0];
    else if (head.lr)
      res = op << k;
    else if (head.ar)
      res = 8'($signed(op) >>> k);
    else
      res = op >> k;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{data: in_data, n: in_n, ar: in_ar, lr: in_lr, rot: in_rot, chain: in_chain};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      acc       <= 8'h00;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      acc       <= 8'h00;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_data  <= res;
        acc       <= res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb/tb_shift_cmd_sequencer.sv - scoreboard bench for shift_cmd_sequencer

module tb_shift_cmd_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [3:0] in_n = 4'd0;
  logic       in_ar = 1'b0;
  logic       in_lr = 1'b0;
  logic       in_rot = 1'b0;
  logic       in_chain = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] level;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  shift_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_n(in_n),
    .in_ar(in_ar), .in_lr(in_lr), .in_rot(in_rot), .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result handshake completes at the next edge when valid && ready.
  always begin
    @(negedge clk);
    #2;
    if (nrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
      end else begin
        check("result", out_data, exp_q.pop_front());
      end
    end
  end

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send(input logic [7:0] d, input logic [3:0] n, input logic ar,
                      input logic lr, input logic rot, input logic ch, input logic [7:0] exp);
    int waited = 0;
    in_data = d; in_n = n; in_ar = ar; in_lr = lr; in_rot = rot; in_chain = ch;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Single command into an idle pipeline: result one cycle after acceptance.
  task automatic send_latency(input string name, input logic [7:0] d, input logic [3:0] n,
                              input logic ar, input logic lr, input logic rot, input logic [7:0] exp);
    send(d, n, ar, lr, rot, 1'b0, exp);
    check({name, "_valid_e0"}, out_valid, 0);
    @(negedge clk);
    check({name, "_valid_e1"}, out_valid, 1);
    @(negedge clk);
  endtask

  initial begin
    // Reset held across edges
    repeat (3) @(negedge clk);
    check("rst_hold_valid", out_valid, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1);

    out_ready = 1'b1;
    // Basic ops
    send_latency("lsr3", 8'hB4, 4'd3, 1'b0, 1'b0, 1'b0, 8'h16);
    send_latency("asr3", 8'hB4, 4'd3, 1'b1, 1'b0, 1'b0, 8'hF6);
    send_latency("lsl2", 8'hB4, 4'd2, 1'b0, 1'b1, 1'b0, 8'hD0);
    send_latency("ror4", 8'hB4, 4'd4, 1'b0, 1'b0, 1'b1, 8'h4B);
    send_latency("rol1", 8'h81, 4'd1, 1'b0, 1'b1, 1'b1, 8'h03);
    // Saturation
    send_latency("lsl12", 8'hFF, 4'd12, 1'b0, 1'b1, 1'b0, 8'h00);
    send_latency("asr15", 8'h80, 4'd15, 1'b1, 1'b0, 1'b0, 8'hFF);
    send_latency("lsr9", 8'h80, 4'd9, 1'b0, 1'b0, 1'b0, 8'h00);
    send_latency("rot12", 8'hB4, 4'd12, 1'b0, 1'b0, 1'b1, 8'hB4);
    send_latency("asl3", 8'hB4, 4'd3, 1'b1, 1'b1, 1'b0, 8'hA0);

    // Chain back-to-back
    send(8'h01, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    send(8'hFF, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    send(8'hFF, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
    repeat (3) @(negedge clk);
    check("chain_drained", exp_q.size(), 0);

    // Backpressure and pointer wrap, three rounds
    for (int rep = 0; rep < 3; rep++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        logic [7:0] d;
        d = 8'(8'h11 + rep * 8'h20 + i * 8'h03);
        send(d, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(d << 1));
      end
      check("bp_level", level, 4);
      check("bp_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      in_data = 8'h55; in_n = 4'd0; in_chain = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_6th_stall_level", level, 4);
      check("bp_hold_data", out_data, 8'(8'(8'h11 + rep * 8'h20) << 1));
      check("bp_hold_valid", out_valid, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        check("bp_drain_valid", out_valid, 1);
        @(negedge clk);
      end
      check("bp_drain_done", out_valid, 0);
      check("bp_drain_level", level, 0);
    end

    // Flush with level=2 and out_valid=1
    out_ready = 1'b0;
    send(8'h01, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    send(8'h02, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    send(8'h03, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    check("fl_pre_level", level, 2);
    check("fl_pre_valid", out_valid, 1);
    flush = 1'b1;
    in_data = 8'h77; in_valid = 1'b1;
    #1;
    check("fl_ready_low", in_ready, 0);
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_level", level, 0);
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b1;
    send(8'hAA, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    check("fl_chain_drained", exp_q.size(), 0);

    // Asynchronous reset mid-stream with level=3
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'hC0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30);
    check("ar_pre_level", level, 3);
    #2;
    nrst = 1'b0;
    #1;
    check("ar_level", level, 0);
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 8'h00);
    check("ar_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send_latency("post_rst", 8'h0F, 4'd4, 1'b0, 1'b1, 1'b0, 8'hF0);
    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Buffered command front-end for the 8-bit shift/rotate datapath. Accepts shift commands over a valid/ready interface, queues them in a 4-entry FIFO, executes one per cycle, and presents the registered 8-bit result downstream under valid/ready. A chain mode takes the previous result as the operand, so multi-step shift sequences run without the producer ever seeing intermediate values.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries (power of two; the test plan assumes 4)

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of FIFO, output register and accumulator
- in_valid  in  1  command present
- in_ready  out  1  command can be accepted (= !fifo_full && !flush)
- in_data  in  8  operand (ignored when in_chain=1)
- in_n  in  4  shift/rotate amount, 0..15
- in_ar  in  1  1 = arithmetic, 0 = logical (meaningful only for a right shift)
- in_lr  in  1  1 = left, 0 = right
- in_rot  in  1  1 = rotate, 0 = shift (rotate takes precedence over ar)
- in_chain  in  1  1 = operand is the accumulator, not in_data
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  8  result
- level  out  3  FIFO occupancy, 0..DEPTH

## Operation
- Accept: in_valid && in_ready at an edge writes {data,n,ar,lr,rot,chain} to the FIFO tail.
- Execute: at an edge where the FIFO is non-empty and (!out_valid || out_ready), pop the head, compute the result, load out_data, set out_valid, and load acc with the same result.
- Otherwise: if out_valid && out_ready and nothing pops, out_valid clears.
- Operand: chain ? acc : data. Chain reads acc as updated by the previously executed command, including a command popped at the immediately preceding edge.
- Amount: effective k = min(n, 8) for every operation.
- Logical left: (op << k) & 0xFF.
- Logical right: op >> k.
- Arithmetic right: vacated bits filled with op[7]; k=8 gives 0x00 or 0xFF.
- Arithmetic left: identical to logical left.
- Rotate left/right by k; k=0 and k=8 are identity.
- FIFO: circular buffer with 2-bit pointers that wrap modulo 4, plus a 3-bit count (`level`). Simultaneous push and pop on a full or empty FIFO keeps count consistent. A push into a full FIFO is impossible because in_ready=0. Push and pop in the same cycle are allowed at any level 1..3.
- flush: at the edge, empties the FIFO, clears out_valid, sets acc=0, and discards any in_valid that cycle. flush has priority over all other events.
- nrst low, at any time including mid-operation: immediately, with no clock edge required, level=0, out_valid=0, out_data=0x00, acc=0x00, pointers=0, and in_ready=1 once flush is low.

## Timing
- Reset values: out_valid=0, out_data=0x00, level=0, in_ready=1 (flush low).
- Latency: a command accepted at edge E0 into an empty pipeline is popped at E1. out_valid is high after E1: one cycle from acceptance to result.
- Throughput: one command per cycle sustained while out_ready=1.
- Capacity: 4 FIFO entries plus 1 output register. With out_ready held low, a 5th command is accepted and the 6th stalls.
- Backpressure: out_data and out_valid hold stable while out_valid && !out_ready.
- in_ready depends only on registered state and flush. It has no combinational path from in_valid or out_ready.
- Results leave in acceptance order, one per handshake.

## Test plan
- Reset: hold nrst=0 across edges, release -> out_valid=0, out_data=0x00, level=0, in_ready=1. Assert nrst mid-stream with level=3 -> all cleared without a clock edge.
- Basic ops on 0xB4:
  - logical right 3 -> 0x16
  - arithmetic right 3 -> 0xF6
  - left 2 -> 0xD0
  - rotate right 4 -> 0x4B
  - on 0x81, rotate left 1 -> 0x03
  - each result arrives one cycle after acceptance
- Saturation:
  - 0xFF logical left n=12 -> 0x00
  - 0x80 arithmetic right n=15 -> 0xFF
  - 0x80 logical right n=9 -> 0x00
  - 0xB4 rotate n=12 -> 0xB4
- Chain, back-to-back, out_ready=1:
  - 0x01 left 1 -> 0x02
  - chain left 3 -> 0x10
  - chain rotate right 5 -> 0x80
- Backpressure and wrap: with out_ready=0, push 6 commands:
  - 5 are accepted, in_ready drops after the 5th, level=4
  - raise out_ready -> 5 results in order on consecutive cycles
  - repeat twice to wrap the pointers
- Flush: with level=2 and out_valid=1, pulse flush with in_valid=1 -> next cycle level=0 and out_valid=0; the command is not accepted and acc=0. A following chain left 1 -> 0x00.
